// File: rtl/fp_add_pipe_if.sv
// fp_add_pipe_if: operand/result bundle for the pipelined binary32 adder.
// The master drives operands, clock-enable and start; the slave (the adder)
// returns the registered sum and the latency-timer done flag.
interface fp_add_pipe_if #(
  parameter int W = 32
);
  logic         clk_en;
  logic         start;
  logic [W-1:0] dataa;
  logic [W-1:0] datab;
  logic [W-1:0] result;
  logic         done;

  modport master (
    output clk_en,
    output start,
    output dataa,
    output datab,
    input  result,
    input  done
  );

  modport slave (
    input  clk_en,
    input  start,
    input  dataa,
    input  datab,
    output result,
    output done
  );
endinterface

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: five-stage IEEE-754 binary32 adder (round to nearest, ties to
// even) with a clock-enable stall and a free-running latency timer that raises
// done ADD_LATENCY clocks after start.
// Optional feature macro: FP_ADD_DENORM_EN
//   defined   -> subnormal inputs/outputs handled exactly (gradual underflow)
//   undefined -> subnormal inputs read as signed zero, tiny results flush to
//                signed zero carrying the sign of the exact result
// The datapath is always five register stages; ADD_LATENCY sets the timer
// terminal count and is expected to stay at 5.
module fp_add_pipe #(
  parameter int FLOAT_DATA_WIDTH = 32,
  parameter int ADD_LATENCY      = 5,
  parameter int CNT_WIDTH        = 10
) (
  input  logic         clk,
  input  logic         rst,
  fp_add_pipe_if.slave bus
);

  localparam logic [31:0]          QNAN    = 32'h7FC0_0000;
  localparam logic [CNT_WIDTH-1:0] LAT_CNT = CNT_WIDTH'(ADD_LATENCY);

  // Stage payloads. "big" is the operand of larger magnitude after the swap.
  typedef struct packed {
    logic        spec;      // result fully decided by special-case logic
    logic [31:0] spec_val;
    logic        sign;      // sign of big operand = sign of a nonzero result
    logic        eff_sub;   // operand signs differ
    logic        zsign;     // sign used if the sum is exactly zero
    logic [7:0]  exp;
    logic [23:0] man_a;
    logic [23:0] man_b;
    logic [7:0]  diff;
  } s1_t;

  typedef struct packed {
    logic        spec;
    logic [31:0] spec_val;
    logic        sign;
    logic        eff_sub;
    logic        zsign;
    logic [7:0]  exp;
    logic [26:0] man_a;     // {hidden, fraction, guard, round, sticky}
    logic [26:0] man_b;     // aligned, sticky folded into bit 0
  } s2_t;

  typedef struct packed {
    logic        spec;
    logic [31:0] spec_val;
    logic        sign;
    logic        zsign;
    logic [7:0]  exp;
    logic [27:0] sum;       // bit 27 is the carry-out of an addition
  } s3_t;

  typedef struct packed {
    logic        spec;
    logic [31:0] spec_val;
    logic        sign;
    logic        zero;      // result is a signed zero
    logic        zsign;
    logic [8:0]  exp;
    logic [26:0] norm;
  } s4_t;

  typedef enum logic [1:0] {T_IDLE, T_COUNT, T_DONE} tstate_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;
  s4_t s4_d, s4_q;
  logic [FLOAT_DATA_WIDTH-1:0] result_d, result_q;

  tstate_t              tstate_d, tstate_q;
  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
  logic                 done_d, done_q;

  // ---------------------------------------------------------------------
  // Operand unpack, one instance per operand (0 = dataa, 1 = datab)
  // ---------------------------------------------------------------------
  logic [1:0][31:0] op_w;
  logic [1:0]       sgn_w;
  logic [1:0][7:0]  exp_w;
  logic [1:0][23:0] man_w;
  logic [1:0]       nan_w;
  logic [1:0]       inf_w;

  assign op_w[0] = bus.dataa;
  assign op_w[1] = bus.datab;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
      logic [7:0]  e_raw;
      logic [22:0] f_raw;
      assign e_raw      = op_w[gi][30:23];
      assign f_raw      = op_w[gi][22:0];
      assign sgn_w[gi]  = op_w[gi][31];
      assign nan_w[gi]  = (e_raw == 8'hFF) && (f_raw != 23'd0);
      assign inf_w[gi]  = (e_raw == 8'hFF) && (f_raw == 23'd0);
      // Exponent field 0 is treated as exponent 1 so subnormals (or the
      // zeros they flush to) line up with the smallest normal binade.
      assign exp_w[gi]  = (e_raw == 8'd0) ? 8'd1 : e_raw;
`ifdef FP_ADD_DENORM_EN
      assign man_w[gi]  = {(e_raw != 8'd0), f_raw};
`else
      assign man_w[gi]  = (e_raw == 8'd0) ? 24'd0 : {1'b1, f_raw};
`endif
    end
  endgenerate

  // S1: classify, order by magnitude, exponent difference
  logic a_big;
  logic bi;
  logic si;
  always_comb begin
    s1_d  = '0;
    a_big = {exp_w[0], man_w[0]} >= {exp_w[1], man_w[1]};
    bi    = ~a_big;
    si    = a_big;
    s1_d.sign    = sgn_w[bi];
    s1_d.exp     = exp_w[bi];
    s1_d.man_a   = man_w[bi];
    s1_d.man_b   = man_w[si];
    s1_d.diff    = exp_w[bi] - exp_w[si];
    s1_d.eff_sub = sgn_w[0] ^ sgn_w[1];
    // x + (-x) gives +0; only (-0) + (-0) keeps a negative zero.
    s1_d.zsign   = sgn_w[0] & sgn_w[1];
    if ((|nan_w) || ((&inf_w) && (sgn_w[0] ^ sgn_w[1]))) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_val = QNAN;
    end else if (inf_w[0]) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_val = {sgn_w[0], 8'hFF, 23'd0};
    end else if (inf_w[1]) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_val = {sgn_w[1], 8'hFF, 23'd0};
    end
  end

  // S2: align the smaller mantissa, keeping guard/round and a sticky OR
  logic [26:0] b_ext;
  logic [26:0] b_shr;
  logic [26:0] b_mask;
  always_comb begin
    s2_d         = '0;
    b_ext        = {s1_q.man_b, 3'b000};
    b_shr        = b_ext >> s1_q.diff[4:0];
    b_mask       = ~({27{1'b1}} << s1_q.diff[4:0]);
    s2_d.spec     = s1_q.spec;
    s2_d.spec_val = s1_q.spec_val;
    s2_d.sign     = s1_q.sign;
    s2_d.eff_sub  = s1_q.eff_sub;
    s2_d.zsign    = s1_q.zsign;
    s2_d.exp      = s1_q.exp;
    s2_d.man_a    = {s1_q.man_a, 3'b000};
    if (s1_q.diff >= 8'd27) begin
      s2_d.man_b = {26'd0, |s1_q.man_b};
    end else begin
      s2_d.man_b = {b_shr[26:1], b_shr[0] | (|(b_ext & b_mask))};
    end
  end

  // S3: magnitude add or subtract; |A| >= |B| so the difference is never negative
  always_comb begin
    s3_d          = '0;
    s3_d.spec     = s2_q.spec;
    s3_d.spec_val = s2_q.spec_val;
    s3_d.sign     = s2_q.sign;
    s3_d.zsign    = s2_q.zsign;
    s3_d.exp      = s2_q.exp;
    if (s2_q.eff_sub) begin
      s3_d.sum = {1'b0, s2_q.man_a} - {1'b0, s2_q.man_b};
    end else begin
      s3_d.sum = {1'b0, s2_q.man_a} + {1'b0, s2_q.man_b};
    end
  end

  // S4: normalise (carry right shift, or leading-zero left shift)
  logic [4:0] lz;
  logic [4:0] sh;
  always_comb begin
    s4_d = '0;
    lz   = 5'd0;
    sh   = 5'd0;
    // Highest set bit wins because later iterations overwrite earlier ones.
    for (int i = 0; i < 27; i++) begin
      if (s3_q.sum[i]) begin
        lz = 5'(26 - i);
      end
    end
    s4_d.spec     = s3_q.spec;
    s4_d.spec_val = s3_q.spec_val;
    s4_d.sign     = s3_q.sign;
    if (s3_q.sum[27]) begin
      s4_d.norm = {s3_q.sum[27:2], |s3_q.sum[1:0]};
      s4_d.exp  = {1'b0, s3_q.exp} + 9'd1;
    end else if (s3_q.sum == 28'd0) begin
      s4_d.zero  = 1'b1;
      s4_d.zsign = s3_q.zsign;
    end else begin
`ifdef FP_ADD_DENORM_EN
      // Stop shifting at exponent 1: what is left is a subnormal.
      sh = lz;
      if ({3'b000, lz} > (s3_q.exp - 8'd1)) begin
        sh = 5'(s3_q.exp - 8'd1);
      end
      s4_d.norm = s3_q.sum[26:0] << sh;
      s4_d.exp  = {1'b0, s3_q.exp} - {4'd0, sh};
`else
      sh = lz;
      if ({3'b000, lz} >= s3_q.exp) begin
        // Below the smallest normal: flush, keeping the exact result's sign.
        s4_d.zero  = 1'b1;
        s4_d.zsign = s3_q.sign;
      end else begin
        s4_d.norm = s3_q.sum[26:0] << sh;
        s4_d.exp  = {1'b0, s3_q.exp} - {4'd0, sh};
      end
`endif
    end
  end

  // S5: round to nearest even, renormalise on carry, detect overflow, pack
  logic [23:0] mant24;
  logic        rnd_up;
  logic [24:0] m25;
  logic [23:0] mant_r;
  logic [8:0]  exp_r;
  logic [7:0]  exp_field;
  always_comb begin
    mant24 = s4_q.norm[26:3];
    rnd_up = s4_q.norm[2] & (s4_q.norm[1] | s4_q.norm[0] | mant24[0]);
    m25    = {1'b0, mant24} + {24'd0, rnd_up};
    if (m25[24]) begin
      mant_r = m25[24:1];
      exp_r  = s4_q.exp + 9'd1;
    end else begin
      mant_r = m25[23:0];
      exp_r  = s4_q.exp;
    end
    // A clear hidden bit only survives at exponent 1, i.e. a subnormal.
    exp_field = mant_r[23] ? exp_r[7:0] : 8'd0;
    if (s4_q.spec) begin
      result_d = s4_q.spec_val;
    end else if (s4_q.zero) begin
      result_d = {s4_q.zsign, 31'd0};
    end else if (exp_r >= 9'd255) begin
      result_d = {s4_q.sign, 8'hFF, 23'd0};
    end else begin
      result_d = {s4_q.sign, exp_field, mant_r[22:0]};
    end
  end

  // Pipeline registers: reset clears everything, clk_en=0 freezes all stages
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      s4_q     <= '0;
      result_q <= '0;
    end else if (bus.clk_en) begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      s4_q     <= s4_d;
      result_q <= result_d;
    end
  end

  // Latency timer next state: start always wins, then count up to terminal
  always_comb begin
    tstate_d = tstate_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    if (bus.start) begin
      tstate_d = T_COUNT;
      cnt_d    = '0;
      done_d   = 1'b0;
    end else begin
      case (tstate_q)
        T_COUNT: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == LAT_CNT) begin
            tstate_d = T_DONE;
            done_d   = 1'b1;
          end
        end
        T_DONE:  done_d = 1'b1;
        default: done_d = 1'b0;
      endcase
    end
  end

  // Latency timer state register, independent of clk_en
  always_ff @(posedge clk) begin
    if (!rst) begin
      tstate_q <= T_IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      tstate_q <= tstate_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_fp_add_pipe.sv
// tb_fp_add_pipe: directed vectors with hand-computed binary32 sums, plus
// latency, stall, timer-restart and reset scenarios for fp_add_pipe.
module tb_fp_add_pipe;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  fp_add_pipe_if #(.W(32)) bus_if ();

  fp_add_pipe #(
    .FLOAT_DATA_WIDTH(32),
    .ADD_LATENCY(5),
    .CNT_WIDTH(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got === expv) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%08h expected=%08h", tag, got, expv);
    end
  endtask

  // Idle cycles with zero operands, enable on, no start.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus_if.dataa  = 32'd0;
      bus_if.datab  = 32'd0;
      bus_if.start  = 1'b0;
      bus_if.clk_en = 1'b1;
    end
  endtask

  // One operation: operands held for exactly one edge (e0) together with start.
  // Result must be on the output after e4, done must rise after e5.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expv);
    @(negedge clk);
    bus_if.dataa  = a;
    bus_if.datab  = b;
    bus_if.start  = 1'b1;
    bus_if.clk_en = 1'b1;
    @(negedge clk);                         // after e0
    bus_if.start = 1'b0;
    bus_if.dataa = 32'd0;
    bus_if.datab = 32'd0;
    check_eq({tag, "_busy"}, {31'd0, bus_if.done}, 32'd0);
    repeat (4) @(negedge clk);              // after e4
    check_eq({tag, "_res"}, bus_if.result, expv);
    $display("op %s: %08h + %08h -> %08h (want %08h)", tag, a, b, bus_if.result, expv);
    @(negedge clk);                         // after e5
    check_eq({tag, "_done"}, {31'd0, bus_if.done}, 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst           = 1'b0;
    bus_if.dataa  = 32'd0;
    bus_if.datab  = 32'd0;
    bus_if.start  = 1'b0;
    bus_if.clk_en = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_result", bus_if.result, 32'd0);
    check_eq("rst_done", {31'd0, bus_if.done}, 32'd0);
    rst = 1'b1;
    idle(2);

    // Basic sums, cancellation, overflow, specials, rounding
    run_op("one_plus_two",   32'h3F800000, 32'h40000000, 32'h40400000);
    run_op("cancel",         32'h3F800000, 32'hBF800000, 32'h00000000);
    run_op("ovf_max",        32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
    run_op("inf_minus_inf",  32'h7F800000, 32'hFF800000, 32'h7FC00000);
    run_op("nan_in",         32'h7FC00001, 32'h3F800000, 32'h7FC00000);
    run_op("tie_even",       32'h3F800000, 32'h33800000, 32'h3F800000);
    run_op("tie_up",         32'h3F800001, 32'h33800000, 32'h3F800002);
    run_op("neg_zeros",      32'h80000000, 32'h80000000, 32'h80000000);
    run_op("mixed_zeros",    32'h80000000, 32'h00000000, 32'h00000000);
    run_op("inf_plus_fin",   32'hFF800000, 32'h3F800000, 32'hFF800000);
    run_op("sub_half",       32'h3F800000, 32'hBF000000, 32'h3F000000);
    run_op("zero_plus_x",    32'h00000000, 32'hC0490FDB, 32'hC0490FDB);
    run_op("carry_renorm",   32'h4B7FFFFF, 32'h3F800000, 32'h4B800000);
    run_op("far_sticky",     32'h3F800000, 32'h00800000, 32'h3F800000);
    run_op("round_ovf",      32'h7F7FFFFF, 32'h73000000, 32'h7F800000);
`ifdef FP_ADD_DENORM_EN
    run_op("tiny_result",    32'h00800000, 32'h80800001, 32'h80000001);
    run_op("sub_input",      32'h00000001, 32'h00000000, 32'h00000001);
`else
    run_op("tiny_result",    32'h00800000, 32'h80800001, 32'h80000000);
    run_op("sub_input",      32'h00000001, 32'h00000000, 32'h00000000);
`endif

    // Stall: clk_en low for edges e2..e4; sum 3.0 + 1.0 appears after e7
    idle(6);
    @(negedge clk);
    bus_if.dataa = 32'h40400000;
    bus_if.datab = 32'h3F800000;
    bus_if.start = 1'b1;
    @(negedge clk);                         // after e0
    bus_if.start = 1'b0;
    bus_if.dataa = 32'd0;
    bus_if.datab = 32'd0;
    @(negedge clk);                         // after e1
    bus_if.clk_en = 1'b0;
    repeat (3) @(negedge clk);              // after e4
    check_eq("stall_hold", bus_if.result, 32'd0);
    bus_if.clk_en = 1'b1;
    @(negedge clk);                         // after e5
    check_eq("stall_timer_done", {31'd0, bus_if.done}, 32'd1);
    @(negedge clk);                         // after e6
    check_eq("stall_not_yet", bus_if.result, 32'd0);
    @(negedge clk);                         // after e7
    check_eq("stall_sum", bus_if.result, 32'h40800000);
    $display("op stall: 40400000 + 3f800000 -> %08h (want 40800000)", bus_if.result);

    // Restart while counting: second start at e2, done after e7 only
    idle(2);
    @(negedge clk);
    bus_if.start = 1'b1;
    @(negedge clk);                         // after e0
    bus_if.start = 1'b0;
    @(negedge clk);                         // after e1
    bus_if.start = 1'b1;
    @(negedge clk);                         // after e2
    bus_if.start = 1'b0;
    repeat (3) @(negedge clk);              // after e5
    check_eq("restart_early", {31'd0, bus_if.done}, 32'd0);
    repeat (2) @(negedge clk);              // after e7
    check_eq("restart_done", {31'd0, bus_if.done}, 32'd1);
    $display("op restart: done=%0d after second start", bus_if.done);

    // Start coinciding with the terminal count: start wins
    idle(1);
    @(negedge clk);
    bus_if.start = 1'b1;
    @(negedge clk);                         // after e0
    bus_if.start = 1'b0;
    repeat (3) @(negedge clk);              // after e3
    @(negedge clk);                         // after e4
    bus_if.start = 1'b1;
    @(negedge clk);                         // after e5
    bus_if.start = 1'b0;
    check_eq("term_start_wins", {31'd0, bus_if.done}, 32'd0);
    repeat (4) @(negedge clk);              // after e9
    check_eq("term_not_yet", {31'd0, bus_if.done}, 32'd0);
    @(negedge clk);                         // after e10
    check_eq("term_done", {31'd0, bus_if.done}, 32'd1);
    $display("op term: done=%0d five clocks after late start", bus_if.done);

    // Reset mid-operation: rst low sampled at e2
    idle(6);
    @(negedge clk);
    bus_if.dataa = 32'h3F800000;
    bus_if.datab = 32'h40000000;
    bus_if.start = 1'b1;
    @(negedge clk);                         // after e0
    bus_if.start = 1'b0;
    bus_if.dataa = 32'd0;
    bus_if.datab = 32'd0;
    @(negedge clk);                         // after e1
    rst = 1'b0;
    @(negedge clk);                         // after e2
    check_eq("midrst_result", bus_if.result, 32'd0);
    check_eq("midrst_done", {31'd0, bus_if.done}, 32'd0);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check_eq("midrst_no_done", {31'd0, bus_if.done}, 32'd0);
    check_eq("midrst_no_result", bus_if.result, 32'd0);
    $display("op midrst: result=%08h done=%0d", bus_if.result, bus_if.done);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
